// File: rtl/dls_pkg.sv
// Shared types and parameter helpers for the dual-lockstep checker.
package dls_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    FAULT = 2'd3
  } dls_state_e;

  localparam int LAG_MAX    = 15;
  localparam int THRESH_MAX = 255;

  // Force the copy lag into the range the fill counter and delay line support.
  function automatic int clamp_lag(input int lag);
    if (lag < 0)       return 0;
    if (lag > LAG_MAX) return LAG_MAX;
    return lag;
  endfunction

  // A threshold of zero would raise a fault without any mismatch, so the floor is 1.
  function automatic int clamp_thresh(input int thresh);
    if (thresh < 1)          return 1;
    if (thresh > THRESH_MAX) return THRESH_MAX;
    return thresh;
  endfunction

endpackage

// File: rtl/dls_delay_line.sv
// Delays the primary bus by LAG cycles so it lines up with the lagging copy.
module dls_delay_line #(
  parameter int DATA_W = 10,
  parameter int LAG    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  if (LAG == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = &{1'b0, clk, rst};
    assign dout = din;
  end else begin : g_shift
    logic [DATA_W-1:0] stage [LAG];

    // Shift register: stage[0] holds last cycle's primary, stage[LAG-1] the oldest.
    always_ff @(posedge clk) begin
      // NOTE: stages are cleared on reset because the outputs must start from a
      // known all-zero history; a pure datapath memory would normally skip this.
      if (rst) begin
        for (int i = 0; i < LAG; i++) stage[i] <= '0;
      end else begin
        // NOTE: non-blocking assignment makes every stage read the pre-edge value
        // of its neighbour; blocking here would collapse the chain into one stage.
        stage[0] <= din;
        for (int i = 1; i < LAG; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[LAG-1];
  end

endmodule

// File: rtl/dls_lockstep_checker.sv
// Dual-lockstep comparator: primary vs. lagging copy with masking, persistence
// filter, sticky fatal flag, saturating error count and first-error syndrome.
module dls_lockstep_checker
  import dls_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int LAG    = 0,
  parameter int THRESH = 1,
  parameter int CNT_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              EN,
  input  logic              CLEAR,
  input  logic [DATA_W-1:0] MASK,
  input  logic [DATA_W-1:0] PRIM_DATA,
  input  logic [DATA_W-1:0] COPY_DATA,
  output logic              DLS_ERROR,
  output logic              DLS_FATAL,
  output logic [CNT_W-1:0]  ERR_COUNT,
  output logic [DATA_W-1:0] ERR_SYNDROME,
  output logic              CHECKING
);

  localparam int         LAG_C     = clamp_lag(LAG);
  localparam int         THRESH_C  = clamp_thresh(THRESH);
  localparam logic [3:0] FILL_LAST = 4'((LAG_C > 0) ? LAG_C - 1 : 0);
  localparam logic [8:0] THRESH_V  = 9'(THRESH_C);

  dls_state_e        state;
  logic [3:0]        fill_cnt;
  logic [7:0]        run_cnt;
  logic [8:0]        run_inc;
  logic              syn_valid;
  logic [DATA_W-1:0] prim_dly;
  logic [DATA_W-1:0] diff;
  logic              comparing;
  logic              mismatch;
  logic              hit_thresh;

  dls_delay_line #(
    .DATA_W (DATA_W),
    .LAG    (LAG_C)
  ) u_delay (
    .clk  (HCLK),
    .rst  (HRESET),
    .din  (PRIM_DATA),
    .dout (prim_dly)
  );

  // Compare point: masked difference, only meaningful once the delay line is primed.
  always_comb begin
    // NOTE: every signal gets a value on every path of this block; a missed
    // assignment in a combinational block infers a latch.
    diff       = (prim_dly ^ COPY_DATA) & ~MASK;
    comparing  = (state == CHECK) || (state == FAULT);
    mismatch   = comparing && (|diff);
    run_inc    = {1'b0, run_cnt} + 9'd1;
    hit_thresh = (state == CHECK) && (run_inc >= THRESH_V);
  end

  // Control FSM: enable sequencing, fill wait, persistence run counter.
  always_ff @(posedge HCLK) begin
    if (HRESET || !EN) begin
      state    <= IDLE;
      fill_cnt <= '0;
      run_cnt  <= '0;
      CHECKING <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LAG_C == 0) begin
            state    <= CHECK;
            CHECKING <= 1'b1;
          end else begin
            state <= FILL;
          end
        end
        FILL: begin
          if (fill_cnt == FILL_LAST) begin
            state    <= CHECK;
            fill_cnt <= '0;
            CHECKING <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 4'd1;
          end
        end
        CHECK: begin
          if (CLEAR || !mismatch) begin
            run_cnt <= '0;
          end else if (hit_thresh) begin
            state   <= FAULT;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_inc[7:0];
          end
        end
        FAULT: begin
          if (CLEAR) state <= CHECK;
        end
        default: begin
          state    <= IDLE;
          CHECKING <= 1'b0;
        end
      endcase
    end
  end

  // Error reporting: registered mismatch, count, first syndrome, sticky fatal.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      DLS_ERROR    <= 1'b0;
      DLS_FATAL    <= 1'b0;
      ERR_COUNT    <= '0;
      ERR_SYNDROME <= '0;
      syn_valid    <= 1'b0;
    end else begin
      DLS_ERROR <= mismatch;
      if (CLEAR) begin
        DLS_FATAL    <= 1'b0;
        ERR_COUNT    <= '0;
        ERR_SYNDROME <= '0;
        syn_valid    <= 1'b0;
      end else if (mismatch) begin
        if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + CNT_W'(1);
        if (!syn_valid) begin
          ERR_SYNDROME <= diff;
          syn_valid    <= 1'b1;
        end
        if (hit_thresh) DLS_FATAL <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dls_lockstep_checker.md
# dls_lockstep_checker

Parametrised dual-lockstep checker for peripheral outputs: compares a primary output bus against its shadow (copy) instance with configurable skew, per-bit masking and a persistence filter. It reports a registered per-cycle mismatch, a sticky fatal fault, a saturating error count and the syndrome of the first mismatch. It sits beside a duplicated peripheral (e.g. AHB VGA: {HSYNC, VSYNC, RGB[7:0]}) and replaces the single-cycle, fixed-width comparator.

## Interface
- DATA_W, default 10: width of compared bus (VGA: HSYNC, VSYNC, RGB[7:0])
- LAG, default 0: cycles by which the copy lags the primary; range 0..15
- THRESH, default 1: consecutive mismatching cycles that raise DLS_FATAL; range 1..255
- CNT_W, default 16: width of ERR_COUNT

- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- EN  in  1  check enable
- CLEAR  in  1  one-cycle pulse: clears ERR_COUNT, ERR_SYNDROME, DLS_FATAL, run counter
- MASK  in  DATA_W  1 = bit excluded from comparison
- PRIM_DATA  in  DATA_W  primary instance outputs
- COPY_DATA  in  DATA_W  copy instance outputs
- DLS_ERROR  out  1  registered mismatch of the compared pair
- DLS_FATAL  out  1  sticky persistent-fault flag
- ERR_COUNT  out  CNT_W  saturating count of mismatching cycles
- ERR_SYNDROME  out  DATA_W  masked XOR of first mismatch since reset/CLEAR
- CHECKING  out  1  high in CHECK or FAULT

## Operation
- Delay line: PRIM_DATA delayed LAG cycles (LAG=0: none). Primary sample of cycle t pairs with COPY_DATA of cycle t+LAG.
- diff = (prim_dly ^ COPY_DATA) & ~MASK; mismatch = |diff, evaluated only in CHECK/FAULT.
- FSM states: IDLE, FILL, CHECK, FAULT.
  - IDLE: no compare. EN=1 -> FILL (LAG>0) or CHECK (LAG=0).
  - FILL: fill counter counts LAG cycles -> CHECK; prevents comparing stale delay-line contents.
  - CHECK: run counter +1 on mismatch, reset to 0 on match; reaching THRESH -> FAULT, DLS_FATAL=1.
  - FAULT: comparison and counting continue; exits only via CLEAR (-> CHECK) or EN=0.
  - EN=0 in any state -> IDLE next cycle; ERR_COUNT, ERR_SYNDROME, DLS_FATAL retained; fill and run counters zeroed.
- ERR_COUNT increments per mismatching cycle, saturates at all-ones.
- ERR_SYNDROME loaded with diff on first mismatch when syndrome-valid flag is 0; later mismatches do not overwrite.
- CLEAR priority: clear wins over a same-cycle mismatch (that mismatch not counted, not captured); DLS_ERROR still reflects it.
- CLEAR with EN=0: clears, state stays IDLE.

## Timing
- Reset (HRESET=1 at edge): state IDLE, DLS_ERROR=0, DLS_FATAL=0, ERR_COUNT=0, ERR_SYNDROME=0, CHECKING=0, delay line zero.
- HRESET mid-operation overrides EN and CLEAR; all state as above next cycle.
- DLS_ERROR: mismatch at compare point cycle c -> DLS_ERROR=1 at c+1 (one register). 0 in IDLE/FILL.
- Copy mismatch in cycle t (vs primary from t-LAG) -> DLS_ERROR at t+1.
- DLS_FATAL rises in the same cycle the THRESH-th consecutive DLS_ERROR is high.
- ERR_COUNT/ERR_SYNDROME update same edge as DLS_ERROR.
- EN rise at edge e: CHECKING=1 from e+LAG+1.

## Structure
- Package dls_pkg: state enum (IDLE, FILL, CHECK, FAULT), LAG_MAX=15 constant, parameter-check helpers.
- Sub-module dls_delay_line (DATA_W, LAG): shift register, pass-through at LAG=0, synchronous reset clear.
- Top holds FSM, counters, syndrome capture.

## Test plan
- LAG=0, THRESH=1: PRIM=COPY=10'h155 for 20 cycles -> DLS_ERROR=0, ERR_COUNT=0; flip COPY bit 3 for 1 cycle -> DLS_ERROR pulses 1 next cycle, DLS_FATAL=1, ERR_COUNT=1, ERR_SYNDROME=10'h008.
- LAG=3: copy = primary delayed 3 -> no errors; EN rise -> CHECKING high 4 cycles later, zero DLS_ERROR during FILL despite garbage.
- THRESH=4: 3 mismatch cycles, 1 match, 3 mismatch -> DLS_FATAL stays 0, ERR_COUNT=6; 4th consecutive -> DLS_FATAL=1.
- MASK=10'h0FF, mismatches only in bits 7:0 -> no error; mismatch in bit 9 -> ERR_SYNDROME=10'h200.
- CLEAR in FAULT with same-cycle mismatch -> ERR_COUNT=0, syndrome 0, DLS_FATAL=0, state CHECK, DLS_ERROR=1 next cycle.
- CNT_W=4: 20 mismatch cycles -> ERR_COUNT saturates at 15; HRESET mid-run -> all outputs 0 next cycle.
